// File: rtl/pe_seq_pkg.sv
// Shared definitions for the bit-serial PE sequencer: command and direction
// encodings, FSM states and the ALU operation length.
package pe_seq_pkg;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_ALU   = 2'b10;
  localparam logic [1:0] OP_SHIFT = 2'b11;

  localparam logic [1:0] DIR_E = 2'b00;
  localparam logic [1:0] DIR_W = 2'b01;
  localparam logic [1:0] DIR_S = 2'b10;
  localparam logic [1:0] DIR_N = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ALU_RUN,
    ST_SH_RD,
    ST_SH_WR
  } state_t;

  // Two setup cycles, W reads, W writes, one drain cycle.
  function automatic int op_len(input int w);
    return 2 * w + 3;
  endfunction

endpackage

// File: rtl/pe_seq_addr_gen.sv
// Base + offset BRAM address adders. Port A can source the destination base
// (ALU write phase); port B can source the A base (SHIFT word pairs).
module pe_seq_addr_gen #(
  parameter int ADDR_W = 10
) (
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_d,
  input  logic [ADDR_W-1:0] off_a,
  input  logic [ADDR_W-1:0] off_b,
  input  logic              a_from_d,
  input  logic              b_from_a,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b
);

  // Sums truncate to ADDR_W, so addresses wrap silently.
  assign addr_a = (a_from_d ? base_d : base_a) + off_a;
  assign addr_b = (b_from_a ? base_a : base_b) + off_b;

endmodule

// File: rtl/pe_sequencer.sv
// Command sequencer for a 16-lane bit-serial PE block (LOAD / ALU / SHIFT).
// Optional macro PE_SEQ_PERF_EN adds a saturating busy_cycles counter.
module pe_sequencer
  import pe_seq_pkg::*;
#(
  parameter int W      = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [3:0]        cmd_alu_sel,
  input  logic [1:0]        cmd_dir,
  input  logic [ADDR_W-1:0] cmd_a,
  input  logic [ADDR_W-1:0] cmd_b,
  input  logic [ADDR_W-1:0] cmd_d,
  input  logic [5:0]        cmd_len,
  input  logic [15:0]       cmd_data,
  output logic              done,
  output logic              pe_run,
  output logic [15:0]       bram_in,
  output logic              wea,
  output logic              web,
  output logic [ADDR_W-1:0] addra,
  output logic [ADDR_W-1:0] addrb,
  output logic [3:0]        alu_sel,
  output logic [6:0]        count,
  output logic              east,
  output logic              west,
  output logic              south,
  output logic              north,
`ifdef PE_SEQ_PERF_EN
  output logic [31:0]       busy_cycles,
`endif
  output state_t            dbg_state
);

  localparam logic [6:0] K_RD    = 7'd2;
  localparam logic [6:0] K_WR    = 7'(W + 2);
  localparam logic [6:0] K_DRAIN = 7'(op_len(W) - 1);

  state_t            state_q, state_d;
  logic [6:0]        k_q, k_d;
  logic [5:0]        i_q, i_d, len_q;
  logic [ADDR_W-1:0] a_q, b_q, d_q;
  logic [15:0]       data_q;
  logic [3:0]        sel_q;
  logic [1:0]        dir_q;
  logic              accept, last, nop_done;

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is registered and high only while idle.
  assign accept    = cmd_valid & cmd_ready;
  assign nop_done  = accept && (cmd_op == OP_NOP);
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    i_d     = i_q;
    last    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_LOAD:  state_d = ST_LOAD;
            OP_ALU:   begin state_d = ST_ALU_RUN; k_d = '0; end
            OP_SHIFT: begin state_d = ST_SH_RD;   i_d = '0; end
            default:  state_d = ST_IDLE;
          endcase
        end
      end
      ST_LOAD: begin
        state_d = ST_IDLE;
        last    = 1'b1;
      end
      ST_ALU_RUN: begin
        if (k_q == K_DRAIN) begin
          state_d = ST_IDLE;
          k_d     = '0;
          last    = 1'b1;
        end else begin
          k_d = k_q + 7'd1;
        end
      end
      ST_SH_RD: state_d = ST_SH_WR;
      ST_SH_WR: begin
        if (i_q == len_q - 6'd1) begin
          state_d = ST_IDLE;
          i_d     = '0;
          last    = 1'b1;
        end else begin
          state_d = ST_SH_RD;
          i_d     = i_q + 6'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values for the cycle the FSM is currently in; registered below.
  logic              run_n, wea_n, web_n, a_en, b_en, a_from_d, b_from_a;
  logic [15:0]       in_n;
  logic [3:0]        sel_n, dirs_n;
  logic [6:0]        cnt_n;
  logic [ADDR_W-1:0] off_a, off_b, gen_a, gen_b;

  always_comb begin
    run_n    = 1'b1;
    in_n     = '0;
    wea_n    = 1'b0;
    web_n    = 1'b0;
    sel_n    = '0;
    cnt_n    = '0;
    dirs_n   = '0;
    a_en     = 1'b0;
    b_en     = 1'b0;
    a_from_d = 1'b0;
    b_from_a = 1'b0;
    off_a    = '0;
    off_b    = '0;
    case (state_q)
      ST_LOAD: begin
        run_n = 1'b0;
        wea_n = 1'b1;
        in_n  = data_q;
        a_en  = 1'b1;
      end
      ST_ALU_RUN: begin
        sel_n = sel_q;
        cnt_n = k_q;
        if (k_q >= K_RD && k_q < K_WR) begin
          a_en  = 1'b1;
          b_en  = 1'b1;
          off_a = ADDR_W'(k_q - K_RD);
          off_b = ADDR_W'(k_q - K_RD);
        end else if (k_q >= K_WR && k_q < K_DRAIN) begin
          a_en     = 1'b1;
          a_from_d = 1'b1;
          off_a    = ADDR_W'(k_q - K_WR);
          wea_n    = 1'b1;
        end
      end
      ST_SH_RD, ST_SH_WR: begin
        a_en     = 1'b1;
        b_en     = 1'b1;
        b_from_a = 1'b1;
        off_a    = ADDR_W'({i_q, 1'b0});
        off_b    = ADDR_W'({i_q, 1'b1});
        wea_n    = (state_q == ST_SH_WR);
        web_n    = (state_q == ST_SH_WR);
        dirs_n   = 4'b0001 << dir_q;
      end
      default: ;
    endcase
  end

  pe_seq_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .base_a   (a_q),
    .base_b   (b_q),
    .base_d   (d_q),
    .off_a    (off_a),
    .off_b    (off_b),
    .a_from_d (a_from_d),
    .b_from_a (b_from_a),
    .addr_a   (gen_a),
    .addr_b   (gen_b)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      i_q     <= '0;
      len_q   <= 6'd1;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      dir_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      i_q     <= i_d;
      if (accept) begin
        a_q    <= cmd_a;
        b_q    <= cmd_b;
        d_q    <= cmd_d;
        data_q <= cmd_data;
        sel_q  <= cmd_alu_sel;
        dir_q  <= cmd_dir;
        len_q  <= (cmd_len == 6'd0) ? 6'd1 : cmd_len;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      pe_run    <= 1'b1;
      bram_in   <= '0;
      wea       <= 1'b0;
      web       <= 1'b0;
      addra     <= '0;
      addrb     <= '0;
      alu_sel   <= '0;
      count     <= '0;
      {north, south, west, east} <= 4'b0000;
    end else begin
      cmd_ready <= (state_d == ST_IDLE);
      done      <= last | nop_done;
      pe_run    <= run_n;
      bram_in   <= in_n;
      wea       <= wea_n;
      web       <= web_n;
      addra     <= a_en ? gen_a : '0;
      addrb     <= b_en ? gen_b : '0;
      alu_sel   <= sel_n;
      count     <= cnt_n;
      {north, south, west, east} <= dirs_n;
    end
  end

`ifdef PE_SEQ_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      busy_cycles <= '0;
    else if (state_q != ST_IDLE && busy_cycles != 32'hFFFF_FFFF)
      busy_cycles <= busy_cycles + 32'd1;
  end
`endif

endmodule

// File: doc/pe_sequencer.md
# pe_sequencer

Command-driven controller that sequences one 16-lane bit-serial PE block: word loads, serialized ALU operations and nearest-neighbour shifts. It accepts one command at a time over a valid/ready handshake. For each command it drives the PE block's BRAM write enables, both port addresses, ALU select, phase counter, shift-direction selects and load-mux control. It sits between the array-level instruction fetch and the PE block, one instance per PE or one shared by a lock-stepped PE row.

## Interface
Parameters:
- W, 32: operand width in bits; ALU op length OP_LEN = 2*W+3 cycles; legal range 1..62.
- ADDR_W, 10: BRAM address width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  00 NOP, 01 LOAD, 10 ALU, 11 SHIFT.
- cmd_alu_sel  in  4  ALU select for ALU ops.
- cmd_dir  in  2  SHIFT direction: 00 E, 01 W, 10 S, 11 N.
- cmd_a, cmd_b, cmd_d  in  ADDR_W each  operand A base, operand B base, destination base (LOAD/SHIFT use cmd_a).
- cmd_len  in  6  SHIFT word-pair count; 0 is treated as 1.
- cmd_data  in  16  LOAD word.
- done  out  1  one-cycle pulse when a command completes.
- pe_run  out  1  drives the PE load-mux control; 0 selects external load data.
- bram_in  out  16  PE load data.
- wea, web  out  1 each  BRAM port write enables.
- addra, addrb  out  ADDR_W each  BRAM port addresses.
- alu_sel  out  4  ALU select.
- count  out  7  ALU phase counter.
- east, west, south, north  out  1 each  one-hot shift selects.

## Operation
- All outputs are registered.
- Reset values: cmd_ready=1, pe_run=1, done=0, all other outputs 0.
- A command is accepted when cmd_valid & cmd_ready; its fields are latched at acceptance.
- States: IDLE, LOAD, ALU_RUN, SH_RD, SH_WR.
- IDLE:
  - NOP: done pulses next cycle; the state stays IDLE.
  - LOAD → LOAD. ALU → ALU_RUN. SHIFT → SH_RD.
- LOAD: one cycle with pe_run=0, wea=1, addra=cmd_a, bram_in=cmd_data. Then → IDLE.
- ALU_RUN: count steps 0..OP_LEN-1; alu_sel is held for the whole run. For count value k:
  - k<2: setup; wea=web=0, addresses 0.
  - 2≤k<W+2: read phase; addra=a+(k-2), addrb=b+(k-2), wea=0.
  - W+2≤k<2W+2: write phase; addra=d+(k-W-2), wea=1, web=0.
  - k=2W+2: drain; wea=0.
  - After k=2W+2 → IDLE.
- SH_RD / SH_WR: for pair index i in 0..len-1:
  - SH_RD: addra=a+2i, addrb=a+2i+1, wea=web=0.
  - SH_WR: same addresses, wea=web=1.
  - The selected direction output is high in both states.
  - After the last SH_WR → IDLE.
- Address arithmetic is modulo 2^ADDR_W and wraps silently.
- count returns to 0 outside ALU_RUN. Direction selects are 0 outside SHIFT.

## Timing
- Command accepted at edge T → first command-cycle outputs valid after edge T+1.
- Completion latencies:
  - LOAD: done at T+2.
  - ALU: done at T+OP_LEN+1.
  - SHIFT: done at T+2*len+1.
  - NOP: done at T+1.
- done and cmd_ready rise in the same cycle; a new command may be accepted on that cycle's edge, giving back-to-back operation with no bubble.
- cmd_valid without cmd_ready is ignored. Held command fields are not sampled after acceptance.
- Reset asserted mid-command: immediate return to IDLE with reset output values; no done pulse; the partial write sequence is abandoned.

## Configuration
- PE_SEQ_PERF_EN defined: adds output busy_cycles[31:0].
  - Increments every cycle the state is not IDLE; saturates at 2^32-1.
  - Cleared by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package pe_seq_pkg holds:
  - the cmd_op encoding constants;
  - the direction encoding;
  - the state enumeration;
  - the OP_LEN function of W.
- One sub-module, pe_seq_addr_gen: base + offset address adders with port-A source mux (a/d), shared by the ALU and SHIFT paths.

## Test plan
- LOAD a=0x010, data=0xBEEF → one cycle of pe_run=0, wea=1, addra=0x010, bram_in=0xBEEF; done at T+2.
- ALU W=32, sel=3, a=0x000, b=0x040, d=0x080 → expected response:
  - count 0..66;
  - reads at addra 0x000..0x01F and addrb 0x040..0x05F;
  - wea=1 with addra 0x080..0x09F;
  - done at T+68.
- SHIFT dir=N, a=0x100, len=3 → expected response:
  - north=1 for 6 cycles;
  - writes at pairs (0x100,0x101), (0x102,0x103), (0x104,0x105);
  - done at T+7.
- Back-to-back: second command valid on the done cycle → accepted the same cycle; no idle gap in outputs.
- Wrap-around: ALU a=0x3F0, W=32 → addra sequence 0x3F0..0x3FF, 0x000..0x00F.
- Reset mid-ALU (count=20) → outputs return to reset values asynchronously; no done pulse; the next command executes normally.
